calc_ctrl: RTL and testbench
============================

// Module: calc_ctrl
// PURPOSE
//  Keypad-driven operand/opcode sequencer directly upstream of the alu block.
//  Consumes scankey's key code + strobe, builds a hex entry operand, keeps an
//  accumulator, and issues one ALU operation per execute key with a one-cycle fue.
//  Captures the ALU result into the accumulator; drives disp for the ssdec chain.
// PARAMETERS
//  DIGITS  8   hex digits in entry register (entry width 4*DIGITS, 1..8, zero-ext to 32)
//  NOPS    12  entries in the op-cycle table (see BEHAVIOUR)
// PORTS
//  clk      in   1   system clock (hz100 at top)
//  rst      in   1   asynchronous, active-high reset
//  key      in   5   scankey out: 0-15 hex digit, 16 op-next, 17 exec, 18 backspace, 19 clear-all
//  strobe   in   1   scankey strobe (level, high while a key is held)
//  alu_out  in   32  alu out (combinational from in1/in2/op)
//  in1      out  32  ALU operand A = accumulator
//  in2      out  32  ALU operand B = entry, zero-extended
//  op       out  5   ALU opcode = table[opidx]
//  fue      out  1   ALU flag-update enable, high exactly one cycle per exec
//  opidx    out  4   current table index (for display)
//  disp     out  32  value to show: entry in ENTRY mode, accumulator in RESULT mode
//  mode     out  1   0 = ENTRY, 1 = RESULT
//  busy     out  1   high in ISSUE state
// BEHAVIOUR
//  Reset (async): acc=0, entry=0, opidx=0, state=ENTRY, mode=0, fresh=0, strobe_q=0;
//   so in1=0, in2=0, op=ALU_ADD, fue=0, disp=0, busy=0.
//  Press detect: strobe_q <= strobe each cycle; press = strobe & ~strobe_q.
//   key sampled on press cycle only; holding a key yields exactly one press.
//  Op table (index 0..11): ADD ADC SUB SBC NEG NOT OR AND BIC XOR CPY CMP.
//  FSM states: ENTRY, ISSUE.
//  ENTRY, press:
//   digit d: if fresh: entry<=d, fresh<=0; else entry<={entry[4*DIGITS-5:0],d}
//            (top digit discarded on overflow). mode<=0.
//   op-next: opidx <= (opidx==NOPS-1) ? 0 : opidx+1. entry/acc unchanged.
//   backspace: entry <= entry>>4; mode<=0.
//   clear-all: acc<=0, entry<=0, opidx<=0, mode<=0, fresh<=0.
//   exec: state<=ISSUE.
//  ISSUE (one cycle): fue=1, busy=1; op/in1/in2 held stable.
//   On the exiting edge: acc<=alu_out unless op==ALU_CMP (acc unchanged);
//   mode<=1, fresh<=1, state<=ENTRY. Latency: press cycle N -> ISSUE N+1 ->
//   acc and alu fout valid from N+2.
//  Presses arriving in ISSUE are dropped (strobe_q still tracked, no replay).
//  fue is combinational from state==ISSUE only; never high in ENTRY.
//  Reset mid-ISSUE: fue drops immediately, acc keeps no partial update.
//  No arithmetic inside this block; all wrap/carry semantics belong to alu.
// STRUCTURE
//  alu_pkg: ALU_* opcode localparams (5-bit), op-table order, key-code constants
//   KEY_OPNEXT=16, KEY_EXEC=17, KEY_BKSP=18, KEY_CLR=19, state enum typedef.
//  Single module; press detector inline (not worth a sub-module). Op table as a
//   constant array indexed by opidx. Top: scankey -> calc_ctrl -> alu, disp -> ssdec x8.
// TESTING
//  1) Reset, press 1,2,3 -> disp=0x00000123, mode=0, fue never high.
//  2) Then exec (opidx 0, ADD, acc 0) -> fue high 1 cycle at N+1; acc=0x123 at N+2, mode=1.
//  3) op-next x2 (SUB), press 1,2,4, exec -> acc=0xFFFFFFFF; alu fout N=1,Z=0.
//  4) Nine digits 1..9 -> entry=0x23456789; backspace -> 0x02345678; held key 50 cycles -> one digit.
//  5) op-next x12 -> opidx wraps 11->0; CMP exec leaves acc unchanged, fue still pulses.
//  6) Assert rst during ISSUE -> fue=0 same cycle; acc=0, opidx=0, disp=0 after release.

Source files
------------

// File: rtl/calc_ctrl_pkg.sv
// Shared opcode, key-code and state definitions for the keypad calculator controller.
// The op table order here fixes which ALU opcode each opidx selects.
package calc_ctrl_pkg;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_ADC = 5'd1;
    localparam logic [4:0] ALU_SUB = 5'd2;
    localparam logic [4:0] ALU_SBC = 5'd3;
    localparam logic [4:0] ALU_NEG = 5'd4;
    localparam logic [4:0] ALU_NOT = 5'd5;
    localparam logic [4:0] ALU_OR  = 5'd6;
    localparam logic [4:0] ALU_AND = 5'd7;
    localparam logic [4:0] ALU_BIC = 5'd8;
    localparam logic [4:0] ALU_XOR = 5'd9;
    localparam logic [4:0] ALU_CPY = 5'd10;
    localparam logic [4:0] ALU_CMP = 5'd11;

    localparam logic [4:0] KEY_OPNEXT = 5'd16;
    localparam logic [4:0] KEY_EXEC   = 5'd17;
    localparam logic [4:0] KEY_BKSP   = 5'd18;
    localparam logic [4:0] KEY_CLR    = 5'd19;

    // Padded to 16 entries so any 4-bit opidx indexes a defined opcode.
    localparam logic [4:0] OP_TABLE [16] = '{
        ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_NEG, ALU_NOT, ALU_OR, ALU_AND,
        ALU_BIC, ALU_XOR, ALU_CPY, ALU_CMP, ALU_ADD, ALU_ADD, ALU_ADD, ALU_ADD
    };

    typedef enum logic {
        ST_ENTRY = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/calc_ctrl.sv
// Keypad operand/opcode sequencer feeding the ALU: builds a hex entry, holds the
// accumulator, and issues one ALU operation (with a single-cycle fue) per exec key.
module calc_ctrl
    import calc_ctrl_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int NOPS   = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  key,
    input  logic        strobe,
    input  logic [31:0] alu_out,
    output logic [31:0] in1,
    output logic [31:0] in2,
    output logic [4:0]  op,
    output logic        fue,
    output logic [3:0]  opidx,
    output logic [31:0] disp,
    output logic        mode,
    output logic        busy
);

    localparam int EW = 4 * DIGITS;

    state_t          state, state_nx;
    logic [31:0]     acc;
    logic [EW-1:0]   entry;
    logic [EW+3:0]   entry_shift;
    logic            fresh;
    logic            strobe_q;
    logic            press;

    assign press       = strobe & ~strobe_q;
    assign entry_shift = {entry, key[3:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) strobe_q <= 1'b0;
        else     strobe_q <= strobe;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_ENTRY;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_ENTRY: if (press && key == KEY_EXEC) state_nx = ST_ISSUE;
            ST_ISSUE: state_nx = ST_ENTRY;
            default:  state_nx = ST_ENTRY;
        endcase
    end

    always_comb begin
        fue  = (state == ST_ISSUE);
        busy = (state == ST_ISSUE);
    end

    // Presses seen while in ISSUE are intentionally dropped, not queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            entry <= '0;
            opidx <= '0;
            mode  <= 1'b0;
            fresh <= 1'b0;
        end else if (state == ST_ISSUE) begin
            if (op != ALU_CMP) acc <= alu_out;
            mode  <= 1'b1;
            fresh <= 1'b1;
        end else if (press) begin
            if (!key[4]) begin
                entry <= fresh ? EW'(key[3:0]) : entry_shift[EW-1:0];
                fresh <= 1'b0;
                mode  <= 1'b0;
            end else begin
                case (key)
                    KEY_OPNEXT: opidx <= (opidx == 4'(NOPS - 1)) ? 4'd0 : opidx + 4'd1;
                    KEY_BKSP: begin
                        entry <= entry >> 4;
                        mode  <= 1'b0;
                    end
                    KEY_CLR: begin
                        acc   <= '0;
                        entry <= '0;
                        opidx <= '0;
                        mode  <= 1'b0;
                        fresh <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in1  = acc;
    assign in2  = 32'(entry);
    assign op   = OP_TABLE[opidx];
    assign disp = mode ? acc : in2;

endmodule

// File: tb/tb_calc_ctrl.sv
// Scoreboarded bench for calc_ctrl with a behavioural ALU closing the loop.
module tb_calc_ctrl;
    import calc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  key;
    logic        strobe;
    logic [31:0] alu_out;
    logic [31:0] in1, in2, disp;
    logic [4:0]  op;
    logic        fue, mode, busy;
    logic [3:0]  opidx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  o;
        logic [31:0] acc;
    } issue_t;

    issue_t      sb[$];
    logic        pend = 1'b0;
    logic [31:0] pend_acc;

    calc_ctrl #(.DIGITS(8), .NOPS(12)) dut (
        .clk(clk), .rst(rst), .key(key), .strobe(strobe), .alu_out(alu_out),
        .in1(in1), .in2(in2), .op(op), .fue(fue), .opidx(opidx),
        .disp(disp), .mode(mode), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (op)
            ALU_ADD, ALU_ADC: alu_out = in1 + in2;
            ALU_SUB, ALU_CMP: alu_out = in1 - in2;
            ALU_SBC:          alu_out = in1 - in2 - 32'd1;
            ALU_NEG:          alu_out = -in2;
            ALU_NOT:          alu_out = ~in2;
            ALU_OR:           alu_out = in1 | in2;
            ALU_AND:          alu_out = in1 & in2;
            ALU_BIC:          alu_out = in1 & ~in2;
            ALU_XOR:          alu_out = in1 ^ in2;
            ALU_CPY:          alu_out = in2;
            default:          alu_out = 32'h0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every fue pulse must match a queued issue; the following cycle checks acc.
    always @(negedge clk) begin
        if (pend) begin
            check("acc_after_issue", in1, pend_acc);
            check("mode_after_issue", 32'(mode), 32'd1);
            pend = 1'b0;
        end
        if (fue) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fue: got fue=1 expected no issue (op=%0d)", op);
            end else begin
                issue_t e;
                e = sb.pop_front();
                check("issue_in1", in1, e.a);
                check("issue_in2", in2, e.b);
                check("issue_op", 32'(op), 32'(e.o));
                pend_acc = e.acc;
                pend = 1'b1;
            end
        end
    end

    task automatic press(input logic [4:0] k);
        @(posedge clk); #2;
        key = k; strobe = 1'b1;
        @(posedge clk); #2;
        strobe = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic exec(input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] o, input logic [31:0] acc_exp);
        issue_t e;
        e.a = a; e.b = b; e.o = o; e.acc = acc_exp;
        sb.push_back(e);
        press(KEY_EXEC);
    endtask

    initial begin
        rst = 1'b1; key = '0; strobe = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_in1", in1, 32'h0);
        check("rst_in2", in2, 32'h0);
        check("rst_op", 32'(op), 32'(ALU_ADD));
        check("rst_fue", 32'(fue), 32'd0);
        check("rst_disp", disp, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_opidx", 32'(opidx), 32'd0);

        // 1) digit entry
        press(5'd1); press(5'd2); press(5'd3);
        check("entry_123", disp, 32'h0000_0123);
        check("entry_mode", 32'(mode), 32'd0);

        // 2) ADD with acc 0
        exec(32'h0, 32'h123, ALU_ADD, 32'h123);
        check("add_disp", disp, 32'h123);
        check("add_mode", 32'(mode), 32'd1);
        check("add_busy", 32'(busy), 32'd0);

        // 3) SUB 0x123 - 0x124
        press(KEY_OPNEXT); press(KEY_OPNEXT);
        check("opidx_sub", 32'(opidx), 32'd2);
        press(5'd1); press(5'd2); press(5'd4);
        check("fresh_entry", disp, 32'h124);
        exec(32'h123, 32'h124, ALU_SUB, 32'hFFFF_FFFF);
        check("sub_acc", in1, 32'hFFFF_FFFF);

        // 4) overflow, backspace, held key
        for (int d = 1; d <= 9; d++) press(5'(d));
        check("overflow_entry", disp, 32'h2345_6789);
        press(KEY_BKSP);
        check("bksp_entry", disp, 32'h0234_5678);
        @(posedge clk); #2;
        key = 5'd5; strobe = 1'b1;
        repeat (50) @(posedge clk);
        #2 strobe = 1'b0;
        @(posedge clk); #2;
        check("held_key", disp, 32'h2345_6785);

        // 5) op table wrap and CMP
        repeat (9) press(KEY_OPNEXT);
        check("opidx_11", 32'(opidx), 32'd11);
        press(KEY_OPNEXT);
        check("opidx_wrap", 32'(opidx), 32'd0);
        repeat (11) press(KEY_OPNEXT);
        check("op_cmp", 32'(op), 32'(ALU_CMP));
        exec(32'hFFFF_FFFF, 32'h2345_6785, ALU_CMP, 32'hFFFF_FFFF);
        check("cmp_disp", disp, 32'hFFFF_FFFF);

        // 6) reset during ISSUE
        @(posedge clk); #2;
        key = KEY_EXEC; strobe = 1'b1;
        @(posedge clk); #2;
        check("issue_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_issue_fue", 32'(fue), 32'd0);
        strobe = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("post_rst_acc", in1, 32'h0);
        check("post_rst_opidx", 32'(opidx), 32'd0);
        check("post_rst_disp", disp, 32'h0);

        // Drain the scoreboard within a bounded wait.
        for (int i = 0; i < 20 && (sb.size() != 0 || pend); i++) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule
